// File: rtl/sr_latch_if.sv
// sr_latch_if: request/status bundle for the synchronous SR storage bank
//   en           update enable, 0 freezes q
//   s, r         per-cell set/reset requests, active-high, level-sensitive
//   conflict_clr clears the sticky conflict flag at a clock edge
//   q, nq        stored state and its exact complement
//   conflict     sticky flag, some enabled cell saw s=r=1
//   master drives requests; slave (the bank) drives state and flag
interface sr_latch_if #(parameter int WIDTH = 1);
  logic en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;
  logic conflict;
  modport master(output en, s, r, conflict_clr, input q, nq, conflict);
  modport slave(input en, s, r, conflict_clr, output q, nq, conflict);
endinterface

// File: rtl/sr_latch.sv
// sr_latch: clocked bank of WIDTH independent SR cells with optional input synchronizers and sticky conflict detector
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset: q=RESET_VALUE, conflict=0, synchronizers cleared
//   bus    sr_latch_if slave: en, s, r, conflict_clr in; q, nq, conflict out
//   CONFLICT_MODE on s=r=1: 0 hold, 1 set, 2 reset, 3 toggle
//   SYNC_STAGES flops on s/r, so q follows an input change after SYNC_STAGES+1 edges
module sr_latch #(
  parameter int WIDTH = 1,
  parameter int CONFLICT_MODE = 0,
  parameter int SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic rst_n,
  sr_latch_if.slave bus
);
  if (WIDTH < 1 || WIDTH > 64 || SYNC_STAGES < 0 || SYNC_STAGES > 3 || CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_params
    $error("sr_latch: illegal parameter value");
  end
  logic [WIDTH-1:0] s_i, r_i, q_r, q_nx, both, hit;
  logic conflict_r;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_i = bus.s;
    assign r_i = bus.r;
  end else begin : g_sync
    logic [WIDTH-1:0] s_sh [SYNC_STAGES];
    logic [WIDTH-1:0] r_sh [SYNC_STAGES];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          s_sh[i] <= '0;
          r_sh[i] <= '0;
        end
      end else begin
        s_sh[0] <= bus.s;
        r_sh[0] <= bus.r;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          s_sh[i] <= s_sh[i-1];
          r_sh[i] <= r_sh[i-1];
        end
      end
    assign s_i = s_sh[SYNC_STAGES-1];
    assign r_i = r_sh[SYNC_STAGES-1];
  end
  always_comb begin
    both = s_i & r_i;
    hit = CONFLICT_MODE == 1 ? '1 : CONFLICT_MODE == 2 ? '0 : CONFLICT_MODE == 3 ? ~q_r : q_r;
    q_nx = bus.en ? (s_i & ~r_i) | (q_r & ~s_i & ~r_i) | (both & hit) : q_r;
  end
  // a new conflict outranks a clear arriving at the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_r <= RESET_VALUE;
      conflict_r <= 1'b0;
    end else begin
      q_r <= q_nx;
      conflict_r <= (bus.en && |both) || (conflict_r && !bus.conflict_clr);
    end
  assign bus.q = q_r;
  assign bus.nq = ~q_r;
  assign bus.conflict = conflict_r;
endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: directed check of the four conflict modes side by side plus a 4-bit, 2-stage-synchronized bank
module tb_sr_latch;
  logic clk = 1'b0;
  logic rst_n;
  logic en, s1, r1, clr;
  logic [3:0] sw, rw;
  logic [3:0] q_m, nq_m, cf_m;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sr_latch_if #(.WIDTH(1)) bm[4] ();
  for (genvar g = 0; g < 4; g++) begin : g_mode
    assign bm[g].en = en;
    assign bm[g].s = s1;
    assign bm[g].r = r1;
    assign bm[g].conflict_clr = clr;
    assign q_m[g] = bm[g].q;
    assign nq_m[g] = bm[g].nq;
    assign cf_m[g] = bm[g].conflict;
    sr_latch #(.WIDTH(1), .CONFLICT_MODE(g), .SYNC_STAGES(0), .RESET_VALUE(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bm[g])
    );
  end
  sr_latch_if #(.WIDTH(4)) bw ();
  assign bw.en = 1'b1;
  assign bw.s = sw;
  assign bw.r = rw;
  assign bw.conflict_clr = 1'b0;
  sr_latch #(.WIDTH(4), .CONFLICT_MODE(0), .SYNC_STAGES(2), .RESET_VALUE(4'b1010)) u_wide (
    .clk(clk), .rst_n(rst_n), .bus(bw)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; s1 = 1'b0; r1 = 1'b0; clr = 1'b0; sw = 4'h0; rw = 4'h0;
    tick(2);
    check("rst_q", q_m, 4'h0);
    check("rst_nq", nq_m, 4'hf);
    check("rst_cf", cf_m, 4'h0);
    check("rst_wq", bw.q, 4'b1010);
    check("rst_wnq", bw.nq, 4'b0101);
    rst_n = 1'b1;
    tick(2);
    check("idle_q", q_m, 4'h0);
    check("idle_nq", nq_m, 4'hf);
    check("idle_cf", cf_m, 4'h0);
    s1 = 1'b1;
    tick();
    check("set_q", q_m, 4'hf);
    check("set_nq", nq_m, 4'h0);
    tick();
    check("set2_q", q_m, 4'hf);
    s1 = 1'b0;
    tick(2);
    check("hold1_q", q_m, 4'hf);
    r1 = 1'b1;
    tick();
    check("rst_req_q", q_m, 4'h0);
    check("rst_req_nq", nq_m, 4'hf);
    tick();
    r1 = 1'b0;
    tick(2);
    check("hold0_q", q_m, 4'h0);
    check("no_conf", cf_m, 4'h0);
    s1 = 1'b1;
    tick();
    r1 = 1'b1;
    tick();
    check("conf1_q", q_m, 4'b0011);
    check("conf1_cf", cf_m, 4'hf);
    tick();
    check("conf2_q", q_m, 4'b1011);
    s1 = 1'b0; r1 = 1'b0;
    tick(2);
    check("sticky_cf", cf_m, 4'hf);
    check("sticky_q", q_m, 4'b1011);
    s1 = 1'b1; r1 = 1'b1; clr = 1'b1;
    tick();
    check("coll_cf", cf_m, 4'hf);
    check("coll_q", q_m, 4'b0011);
    s1 = 1'b0; r1 = 1'b0;
    tick();
    check("clr_cf", cf_m, 4'h0);
    check("clr_q", q_m, 4'b0011);
    clr = 1'b0;
    r1 = 1'b1;
    tick();
    check("pre_en_q", q_m, 4'h0);
    r1 = 1'b0; en = 1'b0; s1 = 1'b1;
    tick(3);
    check("en0_q", q_m, 4'h0);
    check("en0_cf", cf_m, 4'h0);
    r1 = 1'b1;
    tick();
    check("en0_conf_cf", cf_m, 4'h0);
    check("en0_conf_q", q_m, 4'h0);
    r1 = 1'b0; en = 1'b1;
    tick();
    check("en1_q", q_m, 4'hf);
    sw = 4'b0101;
    tick();
    check("lat1_wq", bw.q, 4'b1010);
    tick();
    check("lat2_wq", bw.q, 4'b1010);
    tick();
    check("lat3_wq", bw.q, 4'b1111);
    check("lat3_wnq", bw.nq, 4'b0000);
    check("w_cf", {31'd0, bw.conflict}, 32'd0);
    sw = 4'h0; rw = 4'hf;
    tick();
    rw = 4'h0;
    #3 rst_n = 1'b0;
    #1;
    check("async_wq", bw.q, 4'b1010);
    check("async_wnq", bw.nq, 4'b0101);
    check("async_q", q_m, 4'h0);
    tick();
    rst_n = 1'b1;
    tick(3);
    check("flush_wq", bw.q, 4'b1010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
